afe_inj_sequencer: RTL and testbench

- Sequences charge injection and time-over-threshold (TOT) measurement for the AFE CPLD.
- On START it issues N_INJ injection pulses on a fixed period. For each pulse it measures the latency from the injection rise to the comparator rise, and the comparator high time.
- Each result is offered to the SPI readout logic through a single-entry valid/ready output register.

---
 rtl/afe_pkg.sv | 13 +
 rtl/afe_comp_sync.sv | 28 ++
 rtl/afe_inj_sequencer.sv | 168 ++++++++++++++++
 tb/tb_afe_inj_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/afe_pkg.sv
// Shared types and constants for the AFE injection / TOT sequencer.
package afe_pkg;
    localparam int CNT_W_DEF = 8;
    localparam logic [CNT_W_DEF-1:0] SAT = {CNT_W_DEF{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INJECT  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_WAIT    = 3'd3,
        ST_FINISH  = 3'd4
    } afe_state_e;
endpackage

// File: rtl/afe_comp_sync.sv
// Synchroniser for the asynchronous discriminator output, with edge pulses.
module afe_comp_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_b,
    input  logic i_comp,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);
    logic [STAGES-1:0] r_chain;
    logic              r_prev;

    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_chain <= '0;
            r_prev  <= 1'b0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_comp};
            r_prev  <= r_chain[STAGES-1];
        end
    end

    assign o_sync = r_chain[STAGES-1];
    assign o_rise = o_sync & ~r_prev;
    assign o_fall = ~o_sync & r_prev;
endmodule

// File: rtl/afe_inj_sequencer.sv
// Injection pulse sequencer with per-pulse latency / time-over-threshold measurement
// and a single-entry valid/ready result register.
//   state   | meaning
//   IDLE    | not busy, waiting for START
//   INJECT  | INJ_OUT high for w cycles, measurement running
//   MEASURE | INJ_OUT low, window open until COMP fall or period timeout
//   WAIT    | window closed, waiting for the period to elapse
//   FINISH  | DONE pulse, back to IDLE
module afe_inj_sequencer
    import afe_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_b,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [7:0]       i_n_inj,
    input  logic [CNT_W-1:0] i_period,
    input  logic [CNT_W-1:0] i_width,
    input  logic             i_comp,
    output logic             o_inj_out,
    output logic             o_hit,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [7:0]       o_res_idx,
    output logic [CNT_W-1:0] o_res_lat,
    output logic [CNT_W-1:0] o_res_tot,
    output logic             o_dropped
);
    localparam logic [CNT_W-1:0] SAT_C = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   TWO_C = {{(CNT_W-1){1'b0}}, 2'b10};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == SAT_C) ? v : v + ONE_C;
    endfunction

    afe_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_wm1, r_pm1, r_pc, r_lat, r_tot;
    logic [CNT_W-1:0] w_lat_nxt, w_tot_nxt, w_w_eff, w_p_min, w_p_eff;
    logic [CNT_W:0]   w_w_p2;
    logic [7:0]       r_n, r_idx, w_idx_inc;
    logic             r_seen, r_closed, r_inj, r_hit;
    logic             w_csync, w_rise, w_fall;
    logic             w_start_ok, w_abort, w_in_win, w_pc_end, w_last;
    logic             w_rise_first, w_fall_close, w_win_end, w_inj_start, w_load, w_xfer;
    logic             r_valid, r_dropped;
    logic [7:0]       r_res_idx;
    logic [CNT_W-1:0] r_res_lat, r_res_tot;

    afe_comp_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .i_clk  (i_clk),
        .i_rst_b(i_rst_b),
        .i_comp (i_comp),
        .o_sync (w_csync),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // w+2 is formed one bit wider so a near-full width cannot wrap the period
    assign w_w_eff = (i_width == '0) ? ONE_C : i_width;
    assign w_w_p2  = {1'b0, w_w_eff} + TWO_C;
    assign w_p_min = w_w_p2[CNT_W] ? SAT_C : w_w_p2[CNT_W-1:0];
    assign w_p_eff = (i_period > w_p_min) ? i_period : w_p_min;

    assign w_start_ok   = (r_state == ST_IDLE) && i_start && !i_abort;
    assign w_abort      = (r_state != ST_IDLE) && i_abort;
    assign w_pc_end     = (r_pc >= r_pm1);
    assign w_idx_inc    = r_idx + 8'd1;
    assign w_last       = (r_n != 8'd0) && (w_idx_inc == r_n);
    assign w_rise_first = w_in_win && w_rise && !r_seen;
    assign w_fall_close = w_in_win && w_fall && r_seen && !r_closed;
    assign w_lat_nxt    = (r_seen || w_rise_first) ? r_lat : sat_inc(r_lat);
    assign w_tot_nxt    = w_rise_first ? ONE_C :
                          (r_seen && !r_closed && w_csync) ? sat_inc(r_tot) : r_tot;
    assign w_win_end    = (r_state == ST_MEASURE) && (w_fall_close || r_closed || w_pc_end);
    assign w_inj_start  = (w_state_nxt == ST_INJECT) && (r_state != ST_INJECT);
    assign w_load       = w_win_end && !i_abort;
    assign w_xfer       = r_valid && i_res_ready;

    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:    if (w_start_ok) w_state_nxt = ST_INJECT;
            ST_INJECT:  if (r_pc >= r_wm1) w_state_nxt = ST_MEASURE;
            ST_MEASURE: begin
                if (w_pc_end)                        w_state_nxt = w_last ? ST_FINISH : ST_INJECT;
                else if (w_fall_close || r_closed)   w_state_nxt = ST_WAIT;
            end
            ST_WAIT:    if (w_pc_end) w_state_nxt = w_last ? ST_FINISH : ST_INJECT;
            ST_FINISH:  w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
        if (w_abort) w_state_nxt = ST_IDLE;
    end

    always_comb begin
        o_busy   = (r_state != ST_IDLE);
        o_done   = (r_state == ST_FINISH);
        w_in_win = (r_state == ST_INJECT) || (r_state == ST_MEASURE);
    end

    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_wm1 <= '0; r_pm1 <= '0; r_n <= '0; r_pc <= '0; r_idx <= '0;
            r_lat <= '0; r_tot <= '0; r_seen <= 1'b0; r_closed <= 1'b0;
            r_inj <= 1'b0; r_hit <= 1'b0;
        end else begin
            r_inj <= (w_state_nxt == ST_INJECT);
            r_hit <= w_csync && w_in_win;
            if (w_start_ok) begin
                r_wm1 <= w_w_eff - ONE_C;
                r_pm1 <= w_p_eff - ONE_C;
                r_n   <= i_n_inj;
                r_idx <= '0;
            end else if (w_pc_end && !w_abort &&
                         (r_state == ST_MEASURE || r_state == ST_WAIT)) begin
                r_idx <= w_idx_inc;
            end
            if (w_inj_start)  r_pc <= '0;
            else if (o_busy)  r_pc <= sat_inc(r_pc);
            if (w_inj_start) begin
                r_lat <= '0; r_tot <= '0; r_seen <= 1'b0; r_closed <= 1'b0;
            end else if (w_in_win) begin
                r_lat    <= w_lat_nxt;
                r_tot    <= w_tot_nxt;
                r_seen   <= r_seen | w_rise_first;
                r_closed <= r_closed | w_fall_close;
            end
        end
    end

    // A load beats a simultaneous transfer; a load into a held result is dropped
    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_valid <= 1'b0; r_dropped <= 1'b0;
            r_res_idx <= '0; r_res_lat <= '0; r_res_tot <= '0;
        end else begin
            if (w_load && (!r_valid || w_xfer)) begin
                r_valid   <= 1'b1;
                r_res_idx <= r_idx;
                r_res_lat <= (r_seen || w_rise_first) ? r_lat : SAT_C;
                r_res_tot <= w_tot_nxt;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
            if (w_start_ok)                        r_dropped <= 1'b0;
            else if (w_load && r_valid && !w_xfer) r_dropped <= 1'b1;
        end
    end

    assign o_inj_out   = r_inj;
    assign o_hit       = r_hit;
    assign o_res_valid = r_valid;
    assign o_res_idx   = r_res_idx;
    assign o_res_lat   = r_res_lat;
    assign o_res_tot   = r_res_tot;
    assign o_dropped   = r_dropped;
endmodule

// File: tb/tb_afe_inj_sequencer.sv
// Scenario bench for afe_inj_sequencer: expected results queued at stimulus, compared at transfer.
module tb_afe_inj_sequencer;
    logic       clk = 1'b0, rst_b = 1'b0, start = 1'b0, abort = 1'b0, comp = 1'b0, ready = 1'b1;
    logic [7:0] n_inj = '0, period = '0, width = '0;
    logic       inj_out, hit, busy, done, res_valid, dropped;
    logic [7:0] res_idx, res_lat, res_tot;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] idx;
        logic [7:0] lat;
        logic [7:0] tot;
    } res_t;
    res_t sb[$];
    res_t exp_r;

    always #5 clk = ~clk;

    afe_inj_sequencer #(.CNT_W(8), .SYNC_STAGES(2)) dut (
        .i_clk(clk), .i_rst_b(rst_b), .i_start(start), .i_abort(abort),
        .i_n_inj(n_inj), .i_period(period), .i_width(width), .i_comp(comp),
        .o_inj_out(inj_out), .o_hit(hit), .o_busy(busy), .o_done(done),
        .o_res_valid(res_valid), .i_res_ready(ready), .o_res_idx(res_idx),
        .o_res_lat(res_lat), .o_res_tot(res_tot), .o_dropped(dropped)
    );

    // Returns on the negedge of the first INJECT cycle (cycle 0); scrambles inputs afterwards
    task automatic start_seq(input logic [7:0] n, input logic [7:0] p, input logic [7:0] w);
        @(negedge clk);
        n_inj = n; period = p; width = w; start = 1'b1;
        @(negedge clk);
        start = 1'b0; n_inj = 8'd7; period = 8'd2; width = 8'd0;
    endtask

    task automatic test_reset;
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({inj_out, hit, busy, done, res_valid, dropped, res_idx, res_lat, res_tot} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {inj_out, hit, busy, done, res_valid, dropped, res_idx, res_lat, res_tot});
        end
        rst_b = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle busy=%b want=0", busy); end
    endtask

    task automatic test_basic;
        int t0 = -100, nrise = 0, inj_err = 0, hits = 0, ndone = 0, done_cyc = -1;
        logic prev = 1'b0, exp_inj;
        ready = 1'b1; comp = 1'b0;
        sb.push_back(res_t'{8'd0, 8'd8, 8'd9});
        sb.push_back(res_t'{8'd1, 8'd8, 8'd9});
        start_seq(8'd2, 8'd20, 8'd4);
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (inj_out && !prev) begin t0 = cyc; nrise++; end
            prev    = inj_out;
            exp_inj = (cyc < 4) || (cyc >= 20 && cyc < 24);
            if (inj_out !== exp_inj) inj_err++;
            if (hit) hits++;
            if (done) begin ndone++; done_cyc = cyc; end
            if (res_valid) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL basic_res unexpected got=%h", {res_idx, res_lat, res_tot});
                end else begin
                    exp_r = sb.pop_front();
                    if ({res_idx, res_lat, res_tot} !== exp_r) begin
                        bad++; $display("FAIL basic_res got=%h want=%h", {res_idx, res_lat, res_tot}, exp_r);
                    end
                end
            end
            comp = (cyc - t0 >= 6) && (cyc - t0 < 15);
            @(negedge clk);
        end
        comp = 1'b0;
        total++; if (inj_err !== 0) begin bad++; $display("FAIL basic_inj_pattern errors=%0d want=0", inj_err); end
        total++; if (nrise !== 2)   begin bad++; $display("FAIL basic_rises got=%0d want=2", nrise); end
        total++; if (hits !== 18)   begin bad++; $display("FAIL basic_hit_cycles got=%0d want=18", hits); end
        total++; if (ndone !== 1 || done_cyc !== 40) begin
            bad++; $display("FAIL basic_done count=%0d cyc=%0d want 1 at 40", ndone, done_cyc);
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b want=0", busy); end
        total++; if (sb.size() !== 0) begin bad++; $display("FAIL basic_missing results=%0d want=0", sb.size()); end
    endtask

    task automatic test_no_hit;
        int ninj = 0, ndone = 0, done_cyc = -1;
        ready = 1'b1; comp = 1'b0;
        sb.push_back(res_t'{8'd0, 8'hFF, 8'd0});
        start_seq(8'd1, 8'd16, 8'd3);
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (inj_out) ninj++;
            if (done) begin ndone++; done_cyc = cyc; end
            if (res_valid) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL nohit_res unexpected got=%h", {res_idx, res_lat, res_tot});
                end else begin
                    exp_r = sb.pop_front();
                    if ({res_idx, res_lat, res_tot} !== exp_r) begin
                        bad++; $display("FAIL nohit_res got=%h want=%h", {res_idx, res_lat, res_tot}, exp_r);
                    end
                end
            end
            @(negedge clk);
        end
        total++; if (ninj !== 3) begin bad++; $display("FAIL nohit_inj_cycles got=%0d want=3", ninj); end
        total++; if (ndone !== 1 || done_cyc !== 16) begin
            bad++; $display("FAIL nohit_done count=%0d cyc=%0d want 1 at 16", ndone, done_cyc);
        end
        total++; if (sb.size() !== 0) begin bad++; $display("FAIL nohit_missing results=%0d want=0", sb.size()); end
    endtask

    task automatic test_dropped;
        int first_drop = -1, idx_err = 0, ndone = 0;
        ready = 1'b0; comp = 1'b0;
        start_seq(8'd3, 8'd12, 8'd2);
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (dropped && first_drop < 0) first_drop = cyc;
            if (res_valid && res_idx !== 8'd0) idx_err++;
            if (done) ndone++;
            @(negedge clk);
        end
        total++; if (first_drop !== 24) begin bad++; $display("FAIL drop_cycle got=%0d want=24", first_drop); end
        total++; if (idx_err !== 0) begin bad++; $display("FAIL drop_idx_held errors=%0d want=0", idx_err); end
        total++; if (ndone !== 1) begin bad++; $display("FAIL drop_done count=%0d want=1", ndone); end
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL drop_valid_held got=%b want=1", res_valid); end
        sb.push_back(res_t'{8'd0, 8'hFF, 8'd0});
        ready = 1'b1;
        if (res_valid) begin
            total++;
            exp_r = sb.pop_front();
            if ({res_idx, res_lat, res_tot} !== exp_r) begin
                bad++; $display("FAIL drop_res got=%h want=%h", {res_idx, res_lat, res_tot}, exp_r);
            end
        end
        @(negedge clk);
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL drop_valid_clear got=%b want=0", res_valid); end
        sb.push_back(res_t'{8'd0, 8'hFF, 8'd0});
        start_seq(8'd1, 8'd16, 8'd3);
        total++; if (dropped !== 1'b0) begin bad++; $display("FAIL drop_clear_by_start got=%b want=0", dropped); end
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (res_valid) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL drop_res2 unexpected got=%h", {res_idx, res_lat, res_tot});
                end else begin
                    exp_r = sb.pop_front();
                    if ({res_idx, res_lat, res_tot} !== exp_r) begin
                        bad++; $display("FAIL drop_res2 got=%h want=%h", {res_idx, res_lat, res_tot}, exp_r);
                    end
                end
            end
            @(negedge clk);
        end
        total++; if (sb.size() !== 0) begin bad++; $display("FAIL drop_missing results=%0d want=0", sb.size()); end
    endtask

    task automatic test_abort_cont;
        int nrise = 0, rise_err = 0, ndone = 0;
        logic prev = 1'b0;
        ready = 1'b1; comp = 1'b0;
        for (int i = 0; i < 3; i++) sb.push_back(res_t'{8'(i), 8'hFF, 8'd0});
        start_seq(8'd0, 8'd10, 8'd8);
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (inj_out && !prev) begin
                nrise++;
                if (cyc % 10 != 0) rise_err++;
            end
            prev = inj_out;
            if (done) ndone++;
            if (res_valid) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL abort_res unexpected got=%h", {res_idx, res_lat, res_tot});
                end else begin
                    exp_r = sb.pop_front();
                    if ({res_idx, res_lat, res_tot} !== exp_r) begin
                        bad++; $display("FAIL abort_res got=%h want=%h", {res_idx, res_lat, res_tot}, exp_r);
                    end
                end
            end
            if (cyc == 36) begin
                total++;
                if (inj_out !== 1'b0 || busy !== 1'b0) begin
                    bad++; $display("FAIL abort_stop inj=%b busy=%b want 0 0", inj_out, busy);
                end
            end
            abort = (cyc == 35);
            @(negedge clk);
        end
        abort = 1'b0;
        total++; if (nrise !== 4 || rise_err !== 0) begin
            bad++; $display("FAIL abort_rises got=%0d off_grid=%0d want 4 0", nrise, rise_err);
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL abort_no_done count=%0d want=0", ndone); end
        total++; if (sb.size() !== 0) begin bad++; $display("FAIL abort_missing results=%0d want=0", sb.size()); end
        start = 1'b1; abort = 1'b1; n_inj = 8'd1; period = 8'd10; width = 8'd2;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_over_start busy=%b want=0", busy); end
    endtask

    task automatic test_clamp;
        int inj_err = 0, done_cyc = -1;
        logic exp_inj;
        ready = 1'b1; comp = 1'b0;
        for (int i = 0; i < 3; i++) sb.push_back(res_t'{8'(i), 8'hFF, 8'd0});
        start_seq(8'd3, 8'd1, 8'd0);
        for (int cyc = 0; cyc < 20; cyc++) begin
            exp_inj = (cyc < 9) && (cyc % 3 == 0);
            if (inj_out !== exp_inj) inj_err++;
            if (done) done_cyc = cyc;
            if (res_valid) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL clamp_res unexpected got=%h", {res_idx, res_lat, res_tot});
                end else begin
                    exp_r = sb.pop_front();
                    if ({res_idx, res_lat, res_tot} !== exp_r) begin
                        bad++; $display("FAIL clamp_res got=%h want=%h", {res_idx, res_lat, res_tot}, exp_r);
                    end
                end
            end
            @(negedge clk);
        end
        total++; if (inj_err !== 0) begin bad++; $display("FAIL clamp_inj_pattern errors=%0d want=0", inj_err); end
        total++; if (done_cyc !== 9) begin bad++; $display("FAIL clamp_done cyc=%0d want=9", done_cyc); end
        total++; if (sb.size() !== 0) begin bad++; $display("FAIL clamp_missing results=%0d want=0", sb.size()); end
    endtask

    task automatic test_reset_mid;
        ready = 1'b1; comp = 1'b0;
        start_seq(8'd0, 8'd10, 8'd8);
        @(negedge clk);
        total++; if (inj_out !== 1'b1) begin bad++; $display("FAIL rstmid_pre inj=%b want=1", inj_out); end
        #2 rst_b = 1'b0;
        #1;
        total++;
        if ({inj_out, hit, busy, done, res_valid, dropped, res_idx, res_lat, res_tot} !== '0) begin
            bad++;
            $display("FAIL rstmid_async got=%h want=0",
                     {inj_out, hit, busy, done, res_valid, dropped, res_idx, res_lat, res_tot});
        end
        @(negedge clk);
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0 || inj_out !== 1'b0) begin
            bad++; $display("FAIL rstmid_after busy=%b inj=%b want 0 0", busy, inj_out);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_no_hit;
        test_dropped;
        test_abort_cont;
        test_clamp;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
